// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit/receive path:
//            transmitter state encoding, default bit timing and the protocol
//            byte values exchanged with the turns/crossings controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Transmitter frame phases; PARITY is only reachable in parity builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // 100 MHz system clock / 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Protocol bytes produced by the controller.
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_P = 8'h50;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//            raises tick_o for one cycle on the final count. clear_i forces
//            the count to zero so bit timing can be phase-locked to an event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap on the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART transmitter with a valid/ready byte input. One byte in
//            flight; tx_serial is registered and idles high.
//            Build option UART_TX_PARITY_EN inserts an even-parity bit after
//            data bit 7 (11-bit frame).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       serial_q, serial_d;
  logic       accept;
  logic       tick;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign accept = tx_valid && (state_q == IDLE);

  // Bit timer restarts on acceptance so the start bit is a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear_i(accept),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  // Frame sequencing: next state, bit index, shift register and line level.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is derived from the upcoming state so the output register
    // shows the new bit in the first cycle of that state.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drives idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_serial = serial_q;
  assign tx_ready  = (state_q == IDLE);
  assign tx_busy   = (state_q != IDLE);
  assign tx_done   = (state_q == STOP) && tick;

endmodule

`default_nettype wire
